// File: rtl/exec_datapath_unit.sv
// Execution datapath: registered 8-bit ALU, 256x8 register file with async reads,
// and a combinational 4x4 8-bit matrix-multiply tensor core sharing one clock/reset.
module exec_datapath_unit (
  input  logic         clock_in,
  input  logic         reset_in,
  input  logic         enable_in,
  input  logic [7:0]   opcode_in,
  input  logic [7:0]   alu_input1,
  input  logic [7:0]   alu_input2,
  output logic [7:0]   alu_output,
  input  logic         write_enable_in,
  input  logic [7:0]   write_register_address_in,
  input  logic [7:0]   write_data_in,
  input  logic [7:0]   read_register_address1_in,
  input  logic [7:0]   read_register_address2_in,
  output logic [7:0]   read_data1_out,
  output logic [7:0]   read_data2_out,
  input  logic [127:0] tensor_core_input1,
  input  logic [127:0] tensor_core_input2,
  output logic [127:0] tensor_core_output
);

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned RF_DEPTH = 256;
  localparam int unsigned MAT_N    = 4;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;

  // ALU next-value decode; unknown and tensor-reserved opcodes produce zero
  logic [DATA_W-1:0] alu_next;

  always_comb begin
    alu_next = '0;
    case (opcode_in)
      OP_ADD:  alu_next = alu_input1 + alu_input2;
      OP_SUB:  alu_next = alu_input1 - alu_input2;
      OP_AND:  alu_next = alu_input1 & alu_input2;
      OP_OR:   alu_next = alu_input1 | alu_input2;
      OP_XOR:  alu_next = alu_input1 ^ alu_input2;
      default: alu_next = '0;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      alu_output <= '0;
    end else if (enable_in) begin
      alu_output <= alu_next;
    end
  end

  // Register file: synchronous write and clear, asynchronous reads
  logic [DATA_W-1:0] regs [RF_DEPTH];

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      for (int i = 0; i < int'(RF_DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable_in) begin
      regs[write_register_address_in] <= write_data_in;
    end
  end

  assign read_data1_out = regs[read_register_address1_in];
  assign read_data2_out = regs[read_register_address2_in];

  // Tensor core: C[i][j] = sum_k A[i][k]*B[k][j], truncated to DATA_W bits
  always_comb begin
    logic [DATA_W-1:0] acc;
    acc = '0;
    tensor_core_output = '0;
    for (int i = 0; i < int'(MAT_N); i++) begin
      for (int j = 0; j < int'(MAT_N); j++) begin
        acc = '0;
        for (int k = 0; k < int'(MAT_N); k++) begin
          acc = acc + DATA_W'(tensor_core_input1[(i*MAT_N+k)*DATA_W +: DATA_W] *
                              tensor_core_input2[(k*MAT_N+j)*DATA_W +: DATA_W]);
        end
        tensor_core_output[(i*MAT_N+j)*DATA_W +: DATA_W] = acc;
      end
    end
  end

endmodule

// File: tb/tb_exec_datapath_unit.sv
// Self-checking bench for exec_datapath_unit: directed steps plus randomized
// traffic compared against a behavioural model of ALU, register file and tensor core.
module tb_exec_datapath_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [7:0]   op;
  logic [7:0]   a;
  logic [7:0]   b;
  logic [7:0]   alu_out;
  logic         we;
  logic [7:0]   waddr;
  logic [7:0]   wdata;
  logic [7:0]   raddr1;
  logic [7:0]   raddr2;
  logic [7:0]   rdata1;
  logic [7:0]   rdata2;
  logic [127:0] ta;
  logic [127:0] tb;
  logic [127:0] tc;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [256];
  logic [7:0] alu_exp;

  always #5 clk = ~clk;

  exec_datapath_unit dut (
    .clock_in                  (clk),
    .reset_in                  (rst),
    .enable_in                 (en),
    .opcode_in                 (op),
    .alu_input1                (a),
    .alu_input2                (b),
    .alu_output                (alu_out),
    .write_enable_in           (we),
    .write_register_address_in (waddr),
    .write_data_in             (wdata),
    .read_register_address1_in (raddr1),
    .read_register_address2_in (raddr2),
    .read_data1_out            (rdata1),
    .read_data2_out            (rdata2),
    .tensor_core_input1        (ta),
    .tensor_core_input2        (tb),
    .tensor_core_output        (tc)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and sample away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] alu_ref(input int code, input int x, input int y);
    case (code)
      0:       return 8'((x + y) % 256);
      1:       return 8'((x - y + 256) % 256);
      2:       return 8'(x & y);
      3:       return 8'(x | y);
      4:       return 8'(x ^ y);
      default: return 8'(0);
    endcase
  endfunction

  function automatic logic [127:0] mat_ref(input logic [127:0] ma, input logic [127:0] mb);
    logic [127:0] r;
    int sum;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        sum = 0;
        for (int k = 0; k < 4; k++) begin
          sum += int'(ma[(i*4+k)*8 +: 8]) * int'(mb[(k*4+j)*8 +: 8]);
        end
        r[(i*4+j)*8 +: 8] = 8'(sum % 256);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] fill(input logic [7:0] v);
    logic [127:0] r;
    for (int e = 0; e < 16; e++) r[e*8 +: 8] = v;
    return r;
  endfunction

  initial begin
    logic [127:0] ma;
    logic [127:0] mb;
    logic [127:0] mexp;
    logic         nen;
    logic         nwe;

    rst = 1'b0; en = 1'b0; op = 8'h00; a = 8'h00; b = 8'h00;
    we = 1'b0; waddr = 8'h00; wdata = 8'h00; raddr1 = 8'h00; raddr2 = 8'h00;
    ta = '0; tb = '0;

    // Reset overrides enable and write strobe
    #2;
    rst = 1'b1; en = 1'b1; op = 8'h00; a = 8'h12; b = 8'h34;
    we = 1'b1; waddr = 8'h05; wdata = 8'hAB; raddr1 = 8'h05; raddr2 = 8'h00;
    step();
    rst = 1'b0; en = 1'b0; we = 1'b0;
    #1;
    check("reset_alu", 128'(alu_out), 128'(8'h00));
    check("reset_rf_overrides_we", 128'(rdata1), 128'(8'h00));
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    alu_exp = 8'h00;

    // ALU directed
    en = 1'b1; op = 8'h00; a = 8'hF0; b = 8'h20; step();
    check("alu_add_wrap", 128'(alu_out), 128'(8'h10));
    op = 8'h01; a = 8'h05; b = 8'h07; step();
    check("alu_sub_wrap", 128'(alu_out), 128'(8'hFE));
    op = 8'h04; a = 8'hAA; b = 8'hFF; step();
    check("alu_xor", 128'(alu_out), 128'(8'h55));
    op = 8'h02; a = 8'hF3; b = 8'h3C; step();
    check("alu_and", 128'(alu_out), 128'(8'h30));
    op = 8'h03; a = 8'hA0; b = 8'h05; step();
    check("alu_or", 128'(alu_out), 128'(8'hA5));
    op = 8'h06; a = 8'h11; b = 8'h22; step();
    check("alu_op06_zero", 128'(alu_out), 128'(8'h00));
    op = 8'h00; a = 8'h01; b = 8'h02; step();
    check("alu_add_small", 128'(alu_out), 128'(8'h03));
    en = 1'b0; op = 8'h04; a = 8'h0F; b = 8'hF0; step();
    check("alu_hold_disabled", 128'(alu_out), 128'(8'h03));
    step();
    check("alu_hold_second_edge", 128'(alu_out), 128'(8'h03));
    alu_exp = 8'h03;

    // Register file directed
    we = 1'b1; waddr = 8'h7F; wdata = 8'h3C; raddr1 = 8'h7F; raddr2 = 8'h7F; step();
    check("rf_write_port1", 128'(rdata1), 128'(8'h3C));
    check("rf_write_port2", 128'(rdata2), 128'(8'h3C));
    wdata = 8'h99; #1;
    check("rf_rdw_old", 128'(rdata1), 128'(8'h3C));
    step();
    check("rf_rdw_new", 128'(rdata1), 128'(8'h99));
    we = 1'b0; wdata = 8'h11; step();
    check("rf_we_low", 128'(rdata2), 128'(8'h99));
    we = 1'b1; waddr = 8'h00; wdata = 8'h5A; raddr1 = 8'h00; step();
    we = 1'b0;
    check("rf_reg0_not_zero", 128'(rdata1), 128'(8'h5A));
    mem[8'h7F] = 8'h99; mem[8'h00] = 8'h5A;

    // Tensor core: identity x B = B
    ma = '0; mb = '0;
    for (int i = 0; i < 4; i++) begin
      ma[(i*4+i)*8 +: 8] = 8'h01;
      for (int j = 0; j < 4; j++) mb[(i*4+j)*8 +: 8] = 8'(i*4+j);
    end
    ta = ma; tb = mb; #1;
    check("tc_identity", tc, mb);
    ta = fill(8'h10); tb = fill(8'h10); #1;
    check("tc_overflow_10", tc, fill(8'h00));
    ta = fill(8'h03); tb = fill(8'h03); #1;
    check("tc_all_03", tc, fill(8'h24));
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ma[(i*4+j)*8 +: 8] = 8'(i + j);
        mb[(i*4+j)*8 +: 8] = 8'(j);
        mexp[(i*4+j)*8 +: 8] = 8'((j * (4*i + 6)) % 256);
      end
    end
    ta = ma; tb = mb; #1;
    for (int e = 0; e < 16; e++) begin
      check($sformatf("tc_general_%0d", e), 128'(tc[e*8 +: 8]), 128'(mexp[e*8 +: 8]));
    end

    // Simultaneous operation of all three blocks
    en = 1'b1; op = 8'h01; a = 8'h10; b = 8'h01;
    we = 1'b1; waddr = 8'h40; wdata = 8'hC7; raddr1 = 8'h40; raddr2 = 8'h7F;
    ta = fill(8'h02); tb = fill(8'h05); #1;
    check("sim_tc", tc, fill(8'h28));
    check("sim_rf_before", 128'(rdata1), 128'(8'h00));
    step();
    we = 1'b0;
    check("sim_alu", 128'(alu_out), 128'(8'h0F));
    check("sim_rf_after", 128'(rdata1), 128'(8'hC7));
    check("sim_rf_other", 128'(rdata2), 128'(8'h99));
    mem[8'h40] = 8'hC7; alu_exp = 8'h0F;

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      nen = 1'($urandom_range(0, 3) != 0);
      nwe = 1'($urandom_range(0, 1));
      en = nen; we = nwe;
      op = 8'($urandom_range(0, 7));
      a = 8'($urandom); b = 8'($urandom);
      waddr = 8'($urandom); wdata = 8'($urandom);
      raddr1 = (n % 4 == 0) ? waddr : 8'($urandom);
      raddr2 = 8'($urandom);
      for (int w = 0; w < 4; w++) begin
        ta[w*32 +: 32] = $urandom;
        tb[w*32 +: 32] = $urandom;
      end
      #1;
      check("rand_tc", tc, mat_ref(ta, tb));
      check("rand_rd1_pre", 128'(rdata1), 128'(mem[raddr1]));
      if (nen) alu_exp = alu_ref(int'(op), int'(a), int'(b));
      if (nwe) mem[waddr] = wdata;
      step();
      check("rand_alu", 128'(alu_out), 128'(alu_exp));
      check("rand_rd1_post", 128'(rdata1), 128'(mem[raddr1]));
      check("rand_rd2_post", 128'(rdata2), 128'(mem[raddr2]));
    end
    we = 1'b0; en = 1'b0;

    // Reset clears every register; sweep both ports
    rst = 1'b1; step();
    rst = 1'b0; #1;
    check("reset2_alu", 128'(alu_out), 128'(8'h00));
    for (int i = 0; i < 256; i++) begin
      raddr1 = 8'(i); raddr2 = 8'(255 - i); #1;
      check($sformatf("reset_sweep1_%0d", i), 128'(rdata1), 128'(8'h00));
      check($sformatf("reset_sweep2_%0d", i), 128'(rdata2), 128'(8'h00));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
